id_decode: RTL and testbench

- Decode stage directly downstream of instruction fetch. Consumes the fetch packet (pc, pc_next, order, valid) and the instruction-memory response.
- Buffers a response that arrives while the pipeline is stalled, decodes RV32I fields and immediates, and detects load-use hazards.
- Registers a decoded packet toward execute, and squashes in-flight fetches on redirect.

---
 rtl/rv32i_types.sv | 63 ++++++
 rtl/id_decode_if.sv | 16 +
 rtl/id_decode_imm_gen.sv | 29 ++
 rtl/id_decode.sv | 181 ++++++++++++++++++
 tb/tb_id_decode.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I types for the decode stage: fetch/execute stage packets,
// base opcodes, squash FSM states and the immediate bundle.
package rv32i_types;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1eceb000;

  typedef enum logic [6:0] {
    OP_LUI   = 7'b0110111,
    OP_AUIPC = 7'b0010111,
    OP_JAL   = 7'b1101111,
    OP_JALR  = 7'b1100111,
    OP_BR    = 7'b1100011,
    OP_LOAD  = 7'b0000011,
    OP_STORE = 7'b0100011,
    OP_IMM   = 7'b0010011,
    OP_REG   = 7'b0110011
  } rv32i_opcode_t;

  typedef enum logic {
    SQ_IDLE = 1'b0,
    SQ_DROP = 1'b1
  } squash_state_t;

  typedef struct packed {
    logic [31:0] pc_s;
    logic [31:0] pc_next_s;
    logic [63:0] order_s;
    logic        valid_s;
  } if_id_stage_reg_t;

  typedef struct packed {
    logic [31:0] pc_s;
    logic [31:0] pc_next_s;
    logic [63:0] order_s;
    logic [31:0] inst_s;
    logic        valid_s;
    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [4:0]  rd_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [31:0] imm_s;
    logic        illegal_s;
  } id_ex_stage_reg_t;

  typedef struct packed {
    logic [31:0] i_imm;
    logic [31:0] s_imm;
    logic [31:0] b_imm;
    logic [31:0] u_imm;
    logic [31:0] j_imm;
  } imm_set_t;

  function automatic logic is_base_opcode(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR,
      OP_LOAD, OP_STORE, OP_IMM, OP_REG: return 1'b1;
      default:                           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_decode_if.sv
// Instruction-memory link between fetch (master) and decode (slave).
interface id_decode_if;
  import rv32i_types::*;

  // Handshake: imem_req pulses for one cycle per fetch issued; each request is
  // answered later, in order, by exactly one imem_resp cycle that carries
  // imem_rdata. There is no ready/backpressure: a response must be taken the
  // cycle it arrives, which is why decode keeps a one-word hold buffer.
  logic        imem_req;
  logic        imem_resp;
  logic [31:0] imem_rdata;

  modport master (output imem_req, output imem_resp, output imem_rdata);
  modport slave  (input  imem_req, input  imem_resp, input  imem_rdata);

endinterface

// File: rtl/id_decode_imm_gen.sv
// RV32I immediate generator: all five formats plus the one the opcode selects.
module id_decode_imm_gen
  import rv32i_types::*;
(
  input  logic [31:0] inst,
  output imm_set_t    imms,
  output logic [31:0] imm
);

  always_comb begin
    imms.i_imm = {{20{inst[31]}}, inst[31:20]};
    imms.s_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    imms.b_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    imms.u_imm = {inst[31:12], 12'b0};
    imms.j_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // R-type and unknown opcodes carry no immediate.
    imm = '0;
    case (inst[6:0])
      OP_JALR, OP_LOAD, OP_IMM: imm = imms.i_imm;
      OP_STORE:                 imm = imms.s_imm;
      OP_BR:                    imm = imms.b_imm;
      OP_LUI, OP_AUIPC:         imm = imms.u_imm;
      OP_JAL:                   imm = imms.j_imm;
      default:                  imm = '0;
    endcase
  end

endmodule

// File: rtl/id_decode.sv
// RV32I decode stage: hold buffer, field/immediate decode, load-use hazard,
// squash of in-flight fetches on redirect. ID_RVFI_EN adds inst_s/order_s.
module id_decode
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             move,
  input  logic             flush,
  input  if_id_stage_reg_t if_id_reg,
  id_decode_if.slave       imem,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  output logic             stall_req,
  output id_ex_stage_reg_t id_ex_reg,
  output squash_state_t    dbg_sq_state
);

  squash_state_t sq_state, sq_next;
  logic          pending_q;
  logic          outstanding;
  logic          dropping;
  logic          hold_valid_q;
  logic [31:0]   hold_inst_q;
  logic [31:0]   inst;
  logic          inst_avail;
  logic          uses_rs1, uses_rs2;
  logic [31:0]   imm;
  imm_set_t      imms_unused;

  assign dropping     = (sq_state == SQ_DROP);
  assign dbg_sq_state = sq_state;
  assign outstanding  = imem.imem_req | (pending_q & ~imem.imem_resp);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sq_state  <= SQ_IDLE;
      pending_q <= 1'b0;
    end else begin
      sq_state <= sq_next;
      if (imem.imem_req)       pending_q <= 1'b1;
      else if (imem.imem_resp) pending_q <= 1'b0;
    end
  end

  always_comb begin
    sq_next = sq_state;
    case (sq_state)
      SQ_IDLE: if (flush && outstanding) sq_next = SQ_DROP;
      // A flush that also issues a new request keeps us dropping.
      SQ_DROP: if (imem.imem_resp && !(flush && imem.imem_req)) sq_next = SQ_IDLE;
      default: sq_next = SQ_IDLE;
    endcase
  end

  // The held word wins over a stray response arriving while it is occupied.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid_q <= 1'b0;
      hold_inst_q  <= '0;
    end else if (move || flush) begin
      hold_valid_q <= 1'b0;
    end else if (imem.imem_resp && !dropping && !hold_valid_q) begin
      hold_valid_q <= 1'b1;
      hold_inst_q  <= imem.imem_rdata;
    end
  end

  assign inst       = hold_valid_q ? hold_inst_q : imem.imem_rdata;
  assign inst_avail = hold_valid_q | (imem.imem_resp & ~dropping);

  always_comb begin
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b1;
    case (inst[6:0])
      OP_LUI, OP_AUIPC, OP_JAL: begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
      end
      OP_JALR, OP_LOAD, OP_IMM: uses_rs2 = 1'b0;
      default: ;
    endcase
  end

  assign rs1_addr = uses_rs1 ? inst[19:15] : 5'd0;
  assign rs2_addr = uses_rs2 ? inst[24:20] : 5'd0;

  id_decode_imm_gen u_imm_gen (
    .inst (inst),
    .imms (imms_unused),
    .imm  (imm)
  );

  logic        valid_q, illegal_q;
  logic [31:0] pc_q, pc_next_q, imm_q;
  logic [6:0]  opcode_q, funct7_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q, rs1_q, rs2_q;
  logic [31:0] rvfi_inst;
  logic [63:0] rvfi_order;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      pc_q      <= RESET_PC;
      pc_next_q <= '0;
      opcode_q  <= '0;
      funct3_q  <= '0;
      funct7_q  <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      imm_q     <= '0;
      illegal_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (move) begin
      valid_q   <= if_id_reg.valid_s & inst_avail;
      pc_q      <= if_id_reg.pc_s;
      pc_next_q <= if_id_reg.pc_next_s;
      opcode_q  <= inst[6:0];
      funct3_q  <= inst[14:12];
      funct7_q  <= inst[31:25];
      rd_q      <= inst[11:7];
      rs1_q     <= rs1_addr;
      rs2_q     <= rs2_addr;
      imm_q     <= imm;
      illegal_q <= ~is_base_opcode(inst[6:0]) | (inst[1:0] != 2'b11);
    end
  end

`ifdef ID_RVFI_EN
  logic [31:0] inst_q;
  logic [63:0] order_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_q  <= '0;
      order_q <= '0;
    end else if (move && !flush) begin
      inst_q  <= inst;
      order_q <= if_id_reg.order_s;
    end
  end

  assign rvfi_inst  = inst_q;
  assign rvfi_order = order_q;
`else
  logic unused_order;
  assign unused_order = ^if_id_reg.order_s;
  assign rvfi_inst    = '0;
  assign rvfi_order   = '0;
`endif

  always_comb begin
    id_ex_reg           = '0;
    id_ex_reg.pc_s      = pc_q;
    id_ex_reg.pc_next_s = pc_next_q;
    id_ex_reg.order_s   = rvfi_order;
    id_ex_reg.inst_s    = rvfi_inst;
    id_ex_reg.valid_s   = valid_q;
    id_ex_reg.opcode_s  = opcode_q;
    id_ex_reg.funct3_s  = funct3_q;
    id_ex_reg.funct7_s  = funct7_q;
    id_ex_reg.rd_s      = rd_q;
    id_ex_reg.rs1_s     = rs1_q;
    id_ex_reg.rs2_s     = rs2_q;
    id_ex_reg.imm_s     = imm_q;
    id_ex_reg.illegal_s = illegal_q;
  end

  // Hazard is judged against the instruction already sitting in the output register.
  assign stall_req = valid_q & ex_valid & ex_is_load & (ex_rd != 5'd0) &
                     ((ex_rd == rs1_q) | (ex_rd == rs2_q));

endmodule

// File: tb/tb_id_decode.sv
// Self-checking bench for id_decode: scoreboarded decode packets plus
// directed hazard, squash, hold-buffer and reset checks.
module tb_id_decode;
  import rv32i_types::*;

  localparam logic [31:0] RESET_PC = 32'h1eceb000;
  localparam int PW = $bits(id_ex_stage_reg_t);

  logic             clk = 1'b0;
  logic             rst;
  logic             move, flush;
  if_id_stage_reg_t if_id_reg;
  logic             ex_valid, ex_is_load;
  logic [4:0]       ex_rd;
  logic [4:0]       rs1_addr, rs2_addr;
  logic             stall_req;
  id_ex_stage_reg_t id_ex_reg;
  squash_state_t    dbg_sq_state;

  id_decode_if imem_if ();

  id_decode #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .move         (move),
    .flush        (flush),
    .if_id_reg    (if_id_reg),
    .imem         (imem_if),
    .ex_valid     (ex_valid),
    .ex_is_load   (ex_is_load),
    .ex_rd        (ex_rd),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .stall_req    (stall_req),
    .id_ex_reg    (id_ex_reg),
    .dbg_sq_state (dbg_sq_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [PW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference decode of one instruction into the expected output packet.
  function automatic id_ex_stage_reg_t ref_pkt(input logic [31:0] inst,
                                               input if_id_stage_reg_t f,
                                               input logic avail);
    id_ex_stage_reg_t p;
    logic legal, r1, r2;
    p = '0;
    legal = 1'b1; r1 = 1'b1; r2 = 1'b1;
    p.pc_s      = f.pc_s;
    p.pc_next_s = f.pc_next_s;
`ifdef ID_RVFI_EN
    p.order_s   = f.order_s;
    p.inst_s    = inst;
`endif
    p.valid_s   = f.valid_s & avail;
    p.opcode_s  = inst[6:0];
    p.funct3_s  = inst[14:12];
    p.funct7_s  = inst[31:25];
    p.rd_s      = inst[11:7];
    case (inst[6:0])
      7'h37, 7'h17: begin p.imm_s = {inst[31:12], 12'h000}; r1 = 1'b0; r2 = 1'b0; end
      7'h6f: begin
        p.imm_s = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
        r1 = 1'b0; r2 = 1'b0;
      end
      7'h67, 7'h03, 7'h13: begin p.imm_s = {{20{inst[31]}}, inst[31:20]}; r2 = 1'b0; end
      7'h63: p.imm_s = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      7'h23: p.imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      7'h33: p.imm_s = 32'h0;
      default: begin p.imm_s = 32'h0; legal = 1'b0; end
    endcase
    p.rs1_s = r1 ? inst[19:15] : 5'd0;
    p.rs2_s = r2 ? inst[24:20] : 5'd0;
    p.illegal_s = ~legal | (inst[1:0] != 2'b11);
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    move = 1'b0; flush = 1'b0;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0;
    imem_if.imem_req = 1'b0; imem_if.imem_resp = 1'b0; imem_if.imem_rdata = 32'h0;
  endtask

  // Driver: request, response, optional stall cycles, then one move cycle.
  task automatic issue(input string tag, input logic [31:0] inst, input int stall_cycles);
    if_id_stage_reg_t f;
    logic [31:0] r;
    r = $urandom;
    f.pc_s      = {r[31:2], 2'b00};
    f.pc_next_s = f.pc_s + 32'd4;
    f.order_s   = {32'h0, $urandom};
    f.valid_s   = 1'b1;
    imem_if.imem_req = 1'b1; imem_if.imem_resp = 1'b0; move = 1'b0;
    tick();
    imem_if.imem_req = 1'b0; imem_if.imem_resp = 1'b1;
    imem_if.imem_rdata = inst; if_id_reg = f;
    if (stall_cycles > 0) begin
      tick();
      imem_if.imem_resp = 1'b0;
      imem_if.imem_rdata = $urandom;
      for (int i = 1; i < stall_cycles; i++) tick();
    end
    move = 1'b1;
    exp_q.push_back(ref_pkt(inst, f, 1'b1));
    tick();
    move = 1'b0; imem_if.imem_resp = 1'b0;
    if (exp_q.size() == 0) check({tag, "_sb_empty"}, 1, 0);
    else check(tag, id_ex_reg, exp_q.pop_front());
  endtask

  id_ex_stage_reg_t reset_exp;
  logic [6:0] ops [10];

  initial begin
    reset_exp = '0;
    reset_exp.pc_s = RESET_PC;
    ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h5b};
    rst = 1'b0;
    if_id_reg = '0;
    idle_inputs();
    #12;
    check("reset_pkt", id_ex_reg, reset_exp);
    check("reset_stall", stall_req, 1'b0);
    check("reset_state", dbg_sq_state, SQ_IDLE);
    @(negedge clk) rst = 1'b1;

    // Stall capture: addi x1,x0,5 held for three cycles before move.
    issue("addi_hold", 32'h00500093, 3);
    check("addi_rd", id_ex_reg.rd_s, 5'd1);
    check("addi_rs1", id_ex_reg.rs1_s, 5'd0);
    check("addi_imm", id_ex_reg.imm_s, 32'd5);
    check("addi_valid", id_ex_reg.valid_s, 1'b1);

    issue("b_type", 32'hfe000ee3, 0);
    check("b_imm", id_ex_reg.imm_s, 32'hfffffffc);
    issue("j_type", 32'h800000ef, 1);
    check("j_imm", id_ex_reg.imm_s, 32'hfff00000);
    issue("u_type", 32'h12345037, 0);
    check("u_imm", id_ex_reg.imm_s, 32'h12345000);

    for (int k = 0; k < 16; k++) begin
      logic [31:0] r;
      r = $urandom;
      issue("rand", {r[31:7], ops[$urandom_range(0, 9)]}, $urandom_range(0, 2));
    end

    // Load-use hazard against add x6,x5,x7 in the output register.
    issue("add", 32'h00728333, 0);
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5; #1;
    check("lu_rs1", stall_req, 1'b1);
    ex_rd = 5'd7; #1;
    check("lu_rs2", stall_req, 1'b1);
    ex_rd = 5'd6; #1;
    check("lu_rd_only", stall_req, 1'b0);
    ex_rd = 5'd0; #1;
    check("lu_x0", stall_req, 1'b0);
    ex_rd = 5'd5; ex_is_load = 1'b0; #1;
    check("lu_not_load", stall_req, 1'b0);
    ex_is_load = 1'b1; ex_valid = 1'b0; #1;
    check("lu_ex_invalid", stall_req, 1'b0);
    ex_valid = 1'b1;
    issue("jal_rs1bits", 32'h000280ef, 0);
    check("lu_jal_forced", stall_req, 1'b0);
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0;

    // Combinational register-file addresses.
    imem_if.imem_rdata = 32'h00728333; #1;
    check("rs_r_1", rs1_addr, 5'd5);
    check("rs_r_2", rs2_addr, 5'd7);
    imem_if.imem_rdata = 32'h00728293; #1;
    check("rs_i_2", rs2_addr, 5'd0);
    imem_if.imem_rdata = 32'h000280ef; #1;
    check("rs_j_1", rs1_addr, 5'd0);
    imem_if.imem_rdata = 32'h0;

    issue("illegal_op", 32'h0000007f, 0);
    check("illegal_flag", id_ex_reg.illegal_s, 1'b1);
    check("illegal_valid", id_ex_reg.valid_s, 1'b1);
    issue("illegal_lowbits", 32'h00500090, 1);

    // Flush clears a buffered word; a later move with no response is invalid.
    imem_if.imem_req = 1'b1; tick();
    imem_if.imem_req = 1'b0; imem_if.imem_resp = 1'b1; imem_if.imem_rdata = 32'h00100093; tick();
    imem_if.imem_resp = 1'b0; flush = 1'b1; tick();
    check("flush_kills", id_ex_reg.valid_s, 1'b0);
    check("flush_no_pending", dbg_sq_state, SQ_IDLE);
    flush = 1'b0; move = 1'b1; tick();
    check("flush_clears_hold", id_ex_reg.valid_s, 1'b0);
    move = 1'b0;

    // Flush with an outstanding fetch: the next response is dropped.
    issue("pre_drop", 32'h00a00113, 0);
    imem_if.imem_req = 1'b1; tick();
    imem_if.imem_req = 1'b0; flush = 1'b1; tick();
    check("drop_enter", dbg_sq_state, SQ_DROP);
    check("drop_flush_valid", id_ex_reg.valid_s, 1'b0);
    tick();
    check("drop_reflush", dbg_sq_state, SQ_DROP);
    flush = 1'b0; imem_if.imem_resp = 1'b1; imem_if.imem_rdata = 32'h00000013; move = 1'b1; tick();
    check("drop_valid", id_ex_reg.valid_s, 1'b0);
    check("drop_exit", dbg_sq_state, SQ_IDLE);
    imem_if.imem_resp = 1'b0; tick();
    check("drop_not_held", id_ex_reg.valid_s, 1'b0);
    move = 1'b0;
    issue("post_drop", 32'h00500093, 0);

    // Asynchronous reset between clock edges.
    @(negedge clk); #2;
    rst = 1'b0; #1;
    check("async_rst_valid", id_ex_reg.valid_s, 1'b0);
    check("async_rst_pc", id_ex_reg.pc_s, RESET_PC);
    check("async_rst_pkt", id_ex_reg, reset_exp);
    @(negedge clk) rst = 1'b1;
    issue("after_rst", 32'h00728333, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
